// File: rtl/clk_gate_pkg.sv
// Shared definitions for the per-unit clock-enable controller:
// FSM state encoding and default timing parameters.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_ON   = 2'b00,
        ST_WAKE = 2'b01,
        ST_OFF  = 2'b10
    } unit_state_e;

    localparam int unsigned DEF_IDLE_CYCLES = 8;
    localparam int unsigned DEF_WAKE_CYCLES = 2;

endpackage

// File: rtl/clk_gate_ctrl_unit.sv
// One enable lane: ON/WAKE/OFF FSM with a saturating idle/wake counter.
// All outputs except is_off come straight from flops.
module clk_gate_ctrl_unit
    import clk_gate_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic force_on,
    input  logic req,
    output logic enable,
    output logic ready,
    output logic is_off
);

    localparam int unsigned CNT_NEED = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam logic [CNT_W-1:0] IDLE_LAST = (IDLE_CYCLES == 0) ? '0 : CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

    if (WAKE_CYCLES < 1 || WAKE_CYCLES > 15) begin : g_bad_wake
        $error("clk_gate_ctrl_unit: WAKE_CYCLES must be in 1..15");
    end
    if (CNT_W < 1 || CNT_W > 30 || CNT_NEED > ((2 ** CNT_W) - 1)) begin : g_bad_cnt
        $error("clk_gate_ctrl_unit: CNT_W too small for IDLE_CYCLES/WAKE_CYCLES");
    end

    unit_state_e      r_state;
    unit_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_wake;
    logic             r_enable;
    logic             r_ready;

    assign w_wake    = req | force_on;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ON: begin
                if (w_wake || IDLE_CYCLES == 0) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == IDLE_LAST) begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_OFF: begin
                w_cnt_nxt = '0;
                if (w_wake) begin
                    w_state_nxt = ST_WAKE;
                end
            end
            ST_WAKE: begin
                // A dropped request does not abort the wake; the lane idles down later from ON.
                if (r_cnt == WAKE_LAST) begin
                    w_state_nxt = ST_ON;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_ON;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_ON;
            r_cnt    <= '0;
            r_enable <= 1'b1;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_enable <= (w_state_nxt != ST_OFF);
            r_ready  <= (w_state_nxt == ST_ON);
        end
    end

    assign enable = r_enable;
    assign ready  = r_ready;
    // Next-state view, so the parent's all_off flop updates on the same edge as the states.
    assign is_off = (w_state_nxt == ST_OFF);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller: one gating lane per optional datapath unit,
// plus a registered all-units-off flag.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned NUM_UNITS   = 4,
    parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 force_on,
    input  logic [NUM_UNITS-1:0] active_req,
    output logic [NUM_UNITS-1:0] enable,
    output logic [NUM_UNITS-1:0] unit_ready,
    output logic                 all_off
);

    logic [NUM_UNITS-1:0] w_off_nxt;
    logic                 r_all_off;

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
        clk_gate_ctrl_unit #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES),
            .CNT_W       (CNT_W)
        ) u_unit (
            .clk      (clk),
            .rst      (rst),
            .force_on (force_on),
            .req      (active_req[g]),
            .enable   (enable[g]),
            .ready    (unit_ready[g]),
            .is_off   (w_off_nxt[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_all_off <= 1'b0;
        end else begin
            r_all_off <= &w_off_nxt;
        end
    end

    assign all_off = r_all_off;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: table of per-cycle vectors plus
// hand-written reset, force_on and reset-during-wake sequences.
module tb_clk_gate_ctrl;

    typedef struct {
        logic       f;
        logic [3:0] req;
        logic [3:0] en;
        logic [3:0] rdy;
        logic       ao;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       force_on = 1'b0;
    logic [3:0] active_req = '0;
    logic [3:0] enable, unit_ready;
    logic       all_off;
    logic [3:0] enable0, unit_ready0;
    logic       all_off0;

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    clk_gate_ctrl #(.NUM_UNITS(4), .IDLE_CYCLES(8), .WAKE_CYCLES(2), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .force_on(force_on), .active_req(active_req),
        .enable(enable), .unit_ready(unit_ready), .all_off(all_off)
    );

    // Gating disabled: this instance must stay fully enabled throughout.
    clk_gate_ctrl #(.NUM_UNITS(4), .IDLE_CYCLES(0), .WAKE_CYCLES(2), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .force_on(force_on), .active_req(active_req),
        .enable(enable0), .unit_ready(unit_ready0), .all_off(all_off0)
    );

    task automatic check(input string tag, input logic [3:0] en, input logic [3:0] rdy, input logic ao);
        checks++;
        if ({enable, unit_ready, all_off} !== {en, rdy, ao}) begin
            failures++;
            $display("FAIL %s: got en=%b rdy=%b all_off=%b, expected en=%b rdy=%b all_off=%b",
                     tag, enable, unit_ready, all_off, en, rdy, ao);
        end
        checks++;
        if ({enable0, unit_ready0, all_off0} !== {4'hF, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL %s idle0: got en=%b rdy=%b all_off=%b, expected en=1111 rdy=1111 all_off=0",
                     tag, enable0, unit_ready0, all_off0);
        end
    endtask

    // Called at a negedge: drive inputs, let one posedge happen, check, return at next negedge.
    task automatic step(input string tag, input logic f, input logic [3:0] r,
                        input logic [3:0] en, input logic [3:0] rdy, input logic ao);
        force_on   = f;
        active_req = r;
        @(posedge clk);
        #1;
        check(tag, en, rdy, ao);
        @(negedge clk);
    endtask

    task automatic add(input logic f, input logic [3:0] r, input logic [3:0] en,
                       input logic [3:0] rdy, input logic ao);
        vec_t v;
        v.f = f; v.req = r; v.en = en; v.rdy = rdy; v.ao = ao;
        tbl.push_back(v);
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        // Idle-down after reset: 7 edges still on, 8th edge gates everything.
        for (int i = 0; i < 7; i++) add(0, 4'b0000, 4'hF, 4'hF, 0);
        add(0, 4'b0000, 4'h0, 4'h0, 1);
        add(0, 4'b0000, 4'h0, 4'h0, 1);
        // Wake unit 2 with a single-cycle pulse; ready two edges later.
        add(0, 4'b0100, 4'b0100, 4'b0000, 0);
        add(0, 4'b0000, 4'b0100, 4'b0000, 0);
        add(0, 4'b0000, 4'b0100, 4'b0100, 0);
        for (int i = 0; i < 7; i++) add(0, 4'b0000, 4'b0100, 4'b0100, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 1);
        // Wake all, then the expiry race: unit 1 requested on the would-be gating edge.
        add(0, 4'b1111, 4'hF, 4'h0, 0);
        add(0, 4'b0000, 4'hF, 4'h0, 0);
        add(0, 4'b0000, 4'hF, 4'hF, 0);
        for (int i = 0; i < 7; i++) add(0, 4'b0000, 4'hF, 4'hF, 0);
        add(0, 4'b0010, 4'b0010, 4'b0010, 0);
        for (int i = 0; i < 7; i++) add(0, 4'b0000, 4'b0010, 4'b0010, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 1);

        // Reset asserted mid-cycle: outputs change asynchronously.
        #3 rst = 1'b1;
        #1 check("reset_async", 4'hF, 4'hF, 0);
        @(posedge clk);
        @(posedge clk);
        #1 check("reset_held", 4'hF, 4'hF, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].f, tbl[i].req, tbl[i].en, tbl[i].rdy, tbl[i].ao);
        end

        // force_on pulse from all-OFF, then held force keeps everything on.
        step("force_pulse", 1, 4'b0000, 4'hF, 4'h0, 0);
        step("force_wake1", 0, 4'b0000, 4'hF, 4'h0, 0);
        step("force_wake2", 0, 4'b0000, 4'hF, 4'hF, 0);
        for (int i = 0; i < 5; i++) step("force_idle", 0, 4'b0000, 4'hF, 4'hF, 0);
        for (int i = 0; i < 20; i++) step("force_hold", 1, 4'b0000, 4'hF, 4'hF, 0);
        for (int i = 0; i < 7; i++) step("force_release", 0, 4'b0000, 4'hF, 4'hF, 0);
        step("force_regate", 0, 4'b0000, 4'h0, 4'h0, 1);

        // Reset one cycle into a wake of unit 3.
        step("wake3_start", 0, 4'b1000, 4'b1000, 4'b0000, 0);
        #2 rst = 1'b1;
        #1 check("reset_in_wake", 4'hF, 4'hF, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step("post_rst_idle", 0, 4'b0000, 4'hF, 4'hF, 0);
        step("post_rst_gate", 0, 4'b0000, 4'h0, 4'h0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Per-unit clock-enable controller sitting directly upstream of the clk_gate cells in sail-core.
- Watches activity requests from decode and control for NUM_UNITS optional datapath units, such as the multiplier, divider and CSR file.
- Produces registered enable signals, each feeding one clk_gate instance.
- Applies idle hysteresis before gating a unit.
- Runs a wake handshake, so a consumer never issues work to a unit before its gated clock is running again.

Parameters:
- NUM_UNITS, 4, number of gated units, one enable lane each.
- IDLE_CYCLES, 8, consecutive idle cycles before a unit is gated; 0 = gating disabled (enable held 1).
- WAKE_CYCLES, 2, cycles between enable re-assertion and unit_ready; legal range 1..15.
- CNT_W, 4, width of the per-unit counter; must hold max(IDLE_CYCLES, WAKE_CYCLES).

Ports:
- clk, input, 1, core clock; all state updates on posedge.
- rst, input, 1, asynchronous, active-high reset.
- force_on, input, 1, global override: keeps every unit clocked and wakes any gated unit (debug/test).
- active_req, input, NUM_UNITS, bit i = unit i needed this cycle.
- enable, output, NUM_UNITS, registered clock enable to clk_gate i.
- unit_ready, output, NUM_UNITS, bit i = unit i clock running and usable.
- all_off, output, 1, registered; 1 when every unit is in OFF.

Behaviour:
- Every output is driven from a flop and updates only on posedge clk. This keeps enable stable through the low phase, when the downstream clk_gate samples it on negedge.
- Reset (asynchronous assert, synchronous release): every unit state = ON, counters = 0, enable = all 1s, unit_ready = all 1s, all_off = 0. Units are clocked during and after reset.
- Each unit runs an independent FSM with states ON, OFF and WAKE.
- State ON (enable=1, ready=1):
  - If active_req[i] or force_on is 1, the counter clears to 0.
  - Otherwise the counter increments.
  - If the counter == IDLE_CYCLES-1 and req=0 and force_on=0, the next state is OFF and the counter clears.
  - Result: after exactly IDLE_CYCLES consecutive idle cycles, enable[i] reads 0 on the following edge.
- State OFF (enable=0, ready=0):
  - If active_req[i] or force_on is 1, the next state is WAKE, enable=1 at that same edge, and the counter clears.
- State WAKE (enable=1, ready=0):
  - The counter increments every cycle.
  - When the counter == WAKE_CYCLES-1, the next state is ON, unit_ready[i]=1 and the counter clears.
  - A request that drops during WAKE does not abort the wake. The unit completes WAKE, then idles down through ON normally.
- Latency:
  - Request seen in OFF at edge t: enable rises at edge t, and unit_ready rises at edge t+WAKE_CYCLES.
  - Request seen in ON: no latency.
- Simultaneous events:
  - A request arriving on the same cycle the ON counter would expire wins: the unit stays ON and the counter clears.
  - force_on dominates the idle logic in every state.
- IDLE_CYCLES=0:
  - Each FSM is held in ON: enable=1 and ready=1 constantly.
  - The counter is unused.
- Reset mid-WAKE or mid-idle-count: the unit returns to ON, ready=1 and counter 0, with no intermediate glitch on enable beyond the asynchronous transition to 1.
- all_off = registered AND of (state == OFF) over all units, updated on the same edge as the states.
- Counter arithmetic:
  - The counter is unsigned, CNT_W bits wide.
  - It saturates and never wraps. The FSM exits before the maximum is reached; a saturation guard is still required.
- Elaboration-time checks: WAKE_CYCLES >= 1, and CNT_W large enough, else an elaboration error.

Decomposition:
- Shared package clk_gate_pkg holds:
  - The state encoding: ON=2'b00, WAKE=2'b01, OFF=2'b10.
  - The default localparams for IDLE_CYCLES and WAKE_CYCLES.
- Sub-module clk_gate_ctrl_unit contains one FSM plus counter, with ports clk, rst, force_on, req, enable, ready, is_off.
- The top module generates NUM_UNITS instances and the all_off reduction.

Test Plan:
1. Reset check:
   - Stimulus: assert rst mid-cycle with active_req=0.
   - Response: enable=4'b1111, unit_ready=4'b1111 and all_off=0 immediately, and they remain so during rst.
2. Idle-down, IDLE_CYCLES=8:
   - Stimulus: release rst, active_req=0 for 8 cycles.
   - Response: enable goes to 4'b0000 at the 8th edge after release, and all_off=1 on that same edge.
3. Wake handshake, WAKE_CYCLES=2:
   - Stimulus: from all-OFF, pulse active_req=4'b0100 for one cycle at edge t.
   - Response: enable[2]=1 at t, unit_ready[2]=1 at t+2, all_off=0 at t. Unit 2 then re-gates 8 idle cycles after entering ON.
4. Expiry race:
   - Stimulus: in ON, hold req=0 for 7 cycles, then req=1 on the 8th.
   - Response: enable stays 1 and the counter restarts. 8 further idle cycles are needed to gate.
5. force_on:
   - Stimulus: all units OFF, assert force_on for 1 cycle.
   - Response: all enables=1 next edge, all ready=1 two edges later. With force_on held high for 20 cycles, no unit gates.
6. Reset during WAKE:
   - Stimulus: assert rst one cycle after a wake starts.
   - Response: enable=1 and ready=1 immediately. After release, normal idle-down follows.
